// File: rtl/acc_feeder.sv
// acc_feeder: reads N operands from a 1-cycle-latency memory and streams them into acc_core.
// Each run first clears acc_core with a run pulse. The feeder then counts the returning valid
// ticks and captures the final sum. It pulses done_o one cycle after the last tick.
//
// Handshake: there is no backpressure. mem_ce_o issues one read per cycle in READ, and the
// data arrives on mem_q_i one cycle later. core_valid_o marks that cycle, and core_number_o
// carries the operand alongside it. acc_core answers each operand with one core_valid_i tick
// and its running sum on core_result_i.
module acc_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int AWIDTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [AWIDTH:0]          num_cnt_i,
  input  logic [AWIDTH-1:0]        base_addr_i,
  output logic                     idle_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     mem_ce_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
  output logic                     core_run_o,
  output logic                     core_valid_o,
  output logic [IN_DATA_WIDTH-1:0] core_number_o,
  input  logic                     core_valid_i,
  input  logic [DWIDTH-1:0]        core_result_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [AWIDTH:0]       n_q, n_d;
  logic [AWIDTH-1:0]     base_q, base_d;
  logic [AWIDTH:0]       issue_cnt_q, issue_cnt_d;
  logic [AWIDTH:0]       recv_cnt_q, recv_cnt_d;
  logic [DWIDTH-1:0]     result_q, result_d;
  logic                  core_valid_q, core_valid_d;

  logic accept;
  logic counting;
  logic last_ret;

  // Start is honoured only in IDLE. Return ticks count only while a run is in flight.
  assign accept   = (state_q == S_IDLE) && start_i;
  assign counting = (state_q == S_CLEAR) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign last_ret = counting && core_valid_i && (recv_cnt_q == n_q - CNT_ONE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (num_cnt_i == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_d = S_READ;
      S_READ: begin
        if (last_ret)                            state_d = S_DONE;
        else if (issue_cnt_q == n_q - CNT_ONE)   state_d = S_DRAIN;
      end
      S_DRAIN: if (last_ret) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch the request, advance counters, capture the final sum
  always_comb begin
    n_d          = n_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    result_d     = result_q;
    core_valid_d = (state_q == S_READ);
    if (accept) begin
      n_d         = num_cnt_i;
      base_d      = base_addr_i;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
      result_d    = '0;
    end
    if (state_q == S_READ) issue_cnt_d = issue_cnt_q + CNT_ONE;
    if (counting && core_valid_i) recv_cnt_d = recv_cnt_q + CNT_ONE;
    if (last_ret) result_d = core_result_i;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q          <= '0;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      result_q     <= '0;
      core_valid_q <= 1'b0;
    end else begin
      n_q          <= n_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      result_q     <= result_d;
      core_valid_q <= core_valid_d;
    end
  end

  // Outputs decoded from state; the operand passes straight from memory, gated by its valid
  always_comb begin
    idle_o        = (state_q == S_IDLE);
    done_o        = (state_q == S_DONE);
    core_run_o    = (state_q == S_CLEAR);
    mem_ce_o      = (state_q == S_READ);
    mem_addr_o    = base_q + issue_cnt_q[AWIDTH-1:0];
    core_valid_o  = core_valid_q;
    core_number_o = core_valid_q ? mem_q_i : '0;
    result_o      = result_q;
  end

endmodule

// File: tb/tb_acc_feeder.sv
// Bench for acc_feeder. It contains a behavioural memory and acc_core, and a cycle-indexed
// model of the feeder's external behaviour. Directed scenarios also pin literal results.
module tb_acc_feeder;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [8:0]  num_cnt_i;
  logic [7:0]  base_addr_i;
  logic        idle_o, done_o, mem_ce_o, core_run_o, core_valid_o, core_valid_i;
  logic [15:0] result_o, core_result_i;
  logic [7:0]  mem_addr_o, mem_q_i, core_number_o;

  int checks = 0;
  int errors = 0;
  logic        cmp_en = 1'b0;

  logic [7:0]  mem_arr [256];
  int          read_cnt [256];
  logic [7:0]  addr_q [$];
  logic [15:0] exp_q [$];
  int          done_cnt = 0;
  int          ce_cnt = 0;
  int          run_cnt = 0;

  acc_feeder #(.IN_DATA_WIDTH(8), .DWIDTH(16), .AWIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_cnt_i(num_cnt_i),
    .base_addr_i(base_addr_i), .idle_o(idle_o), .done_o(done_o), .result_o(result_o),
    .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_q_i(mem_q_i),
    .core_run_o(core_run_o), .core_valid_o(core_valid_o), .core_number_o(core_number_o),
    .core_valid_i(core_valid_i), .core_result_i(core_result_i)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency memory
  always @(posedge clk) if (mem_ce_o) mem_q_i <= mem_arr[mem_addr_o];

  // acc_core: clear on run, one result tick per operand, one cycle later
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_valid_i  <= 1'b0;
      core_result_i <= '0;
    end else if (core_run_o) begin
      core_valid_i  <= 1'b0;
      core_result_i <= '0;
    end else if (core_valid_o) begin
      core_valid_i  <= 1'b1;
      core_result_i <= core_result_i + 16'(core_number_o);
    end else begin
      core_valid_i  <= 1'b0;
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] calc_sum(input int n, input int base);
    int unsigned s = 0;
    for (int i = 0; i < n; i++) s += mem_arr[(base + i) % 256];
    return 16'(s);
  endfunction

  // Model: a run is a sequence of cycles k=1..D after the accepted start edge
  logic        m_active;
  int          m_k, m_n, m_base;
  logic [15:0] m_sum, m_held;

  // Model state update
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_held   <= '0;
      exp_q.delete();
    end else if (m_active) begin
      if (m_k == ((m_n == 0) ? 1 : m_n + 4)) begin
        m_active <= 1'b0;
        m_held   <= m_sum;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (start_i) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_n      <= int'(num_cnt_i);
      m_base   <= int'(base_addr_i);
      m_sum    <= calc_sum(int'(num_cnt_i), int'(base_addr_i));
      m_held   <= '0;
      exp_q.push_back(calc_sum(int'(num_cnt_i), int'(base_addr_i)));
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin : compare
    int d;
    logic e_run, e_ce, e_val, e_done;
    logic [15:0] e_res;
    if (cmp_en) begin
      d      = (m_n == 0) ? 1 : m_n + 4;
      e_run  = m_active && m_n > 0 && m_k == 1;
      e_ce   = m_active && m_n > 0 && m_k >= 2 && m_k <= m_n + 1;
      e_val  = m_active && m_n > 0 && m_k >= 3 && m_k <= m_n + 2;
      e_done = m_active && m_k == d;
      e_res  = m_active ? (e_done ? m_sum : 16'd0) : m_held;
      check("idle", idle_o, !m_active);
      check("run", core_run_o, e_run);
      check("mem_ce", mem_ce_o, e_ce);
      check("core_valid", core_valid_o, e_val);
      check("done", done_o, e_done);
      check("result", result_o, e_res);
      if (e_ce) check("mem_addr", mem_addr_o, (m_base + m_k - 2) % 256);
      if (e_val) check("number", core_number_o, mem_arr[(m_base + m_k - 3) % 256]);
      if (e_done && exp_q.size() > 0) check("sb_result", result_o, exp_q.pop_front());
    end
  end

  // Activity logs used by the directed scenarios
  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (core_run_o) run_cnt++;
    if (mem_ce_o) begin
      ce_cnt++;
      addr_q.push_back(mem_addr_o);
      read_cnt[mem_addr_o]++;
    end
  end

  // Wait for done_o; dcyc is the cycle index counted from the first cycle after the call
  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (done_o) begin
        dcyc = c;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got none expected done_o within 600 cycles");
    end
    @(posedge clk);
    #2;
  endtask

  // Driver: pulse start for one cycle and wait for completion
  task automatic run_op(input int n, input int base, output int dcyc);
    start_i     = 1'b1;
    num_cnt_i   = 9'(n);
    base_addr_i = 8'(base);
    @(posedge clk);
    #2;
    start_i = 1'b0;
    wait_done(dcyc);
  endtask

  initial begin
    int dc, dn0, ce0, run0, bad;
    reset_n = 1'b0;
    start_i = 1'b0;
    num_cnt_i = '0;
    base_addr_i = '0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i]  = 8'(i * 7 + 3);
      read_cnt[i] = 0;
    end
    mem_arr[0] = 8'd1; mem_arr[1] = 8'd2; mem_arr[2] = 8'd3; mem_arr[3] = 8'd4;
    mem_arr[8'hFE] = 8'h10; mem_arr[8'hFF] = 8'h20;
    repeat (3) @(posedge clk);
    #2;
    check("rst_idle", idle_o, 1);
    check("rst_done", done_o, 0);
    check("rst_mem_ce", mem_ce_o, 0);
    check("rst_run", core_run_o, 0);
    check("rst_valid", core_valid_o, 0);
    check("rst_result", result_o, 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(posedge clk);
    #2;

    // Basic run of four operands
    run0 = run_cnt;
    run_op(4, 0, dc);
    check("s1_done_cycle", dc, 8);
    check("s1_result", result_o, 10);
    check("s1_run_pulses", run_cnt - run0, 1);

    // A start during READ is ignored
    dn0 = done_cnt;
    start_i = 1'b1; num_cnt_i = 9'd4; base_addr_i = 8'd0;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    start_i = 1'b1; num_cnt_i = 9'd2; base_addr_i = 8'h10;
    @(posedge clk); #2;
    start_i = 1'b0;
    wait_done(dc);
    repeat (4) @(posedge clk);
    #2;
    check("s5_done_pulses", done_cnt - dn0, 1);
    check("s5_result", result_o, 10);

    // Address wrap
    addr_q.delete();
    run_op(4, 8'hFE, dc);
    check("s3_addr_count", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      check("s3_addr0", addr_q[0], 8'hFE);
      check("s3_addr1", addr_q[1], 8'hFF);
      check("s3_addr2", addr_q[2], 8'h00);
      check("s3_addr3", addr_q[3], 8'h01);
    end
    check("s3_result", result_o, 51);

    // Zero-length request
    ce0 = ce_cnt; run0 = run_cnt;
    run_op(0, 5, dc);
    check("s4_done_cycle", dc, 1);
    check("s4_result", result_o, 0);
    check("s4_no_reads", ce_cnt - ce0, 0);
    check("s4_no_run", run_cnt - run0, 0);

    // Reset in the middle of READ, then a normal run
    dn0 = done_cnt;
    start_i = 1'b1; num_cnt_i = 9'd8; base_addr_i = 8'd0;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_idle", idle_o, 1);
    check("s6_mem_ce", mem_ce_o, 0);
    check("s6_result", result_o, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("s6_no_done", done_cnt - dn0, 0);
    run_op(4, 0, dc);
    check("s6_done_cycle", dc, 8);
    check("s6_result_after", result_o, 10);

    // Full 256-operand run
    for (int i = 0; i < 256; i++) begin
      mem_arr[i]  = 8'hFF;
      read_cnt[i] = 0;
    end
    run_op(256, 0, dc);
    check("s2_done_cycle", dc, 260);
    check("s2_result", result_o, 65280);
    bad = 0;
    for (int i = 0; i < 256; i++) if (read_cnt[i] != 1) bad++;
    check("s2_reads_once", bad, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
